// File: rtl/cci_mpf_sim_pkg.sv
// Shared types and constants for the simulated CCI host response model.
package cci_mpf_sim_pkg;

    localparam int LINE_ADDR_WIDTH = 42;
    localparam int DATA_WIDTH      = 512;
    localparam int MDATA_WIDTH     = 16;
    localparam int STAMP_WIDTH     = 16;

    localparam logic [STAMP_WIDTH-1:0] LFSR_SEED = 16'hACE1;

    // One queued request; channel 0 leaves data at zero.
    typedef struct packed {
        logic [LINE_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]      data;
        logic [MDATA_WIDTH-1:0]     mdata;
        logic [STAMP_WIDTH-1:0]     stamp;
    } t_sim_req_entry;

    // Maximal-length 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1).
    function automatic logic [STAMP_WIDTH-1:0] lfsr_next(input logic [STAMP_WIDTH-1:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/cci_mpf_sim_host_rsp_if.sv
// CCI request/response bundle between the shim stack (master) and the host model (slave).
interface cci_mpf_sim_host_rsp_if;
    import cci_mpf_sim_pkg::*;

    logic                       c0_req_valid;
    logic [LINE_ADDR_WIDTH-1:0] c0_req_addr;
    logic [MDATA_WIDTH-1:0]     c0_req_mdata;
    logic                       c1_req_valid;
    logic [LINE_ADDR_WIDTH-1:0] c1_req_addr;
    logic [DATA_WIDTH-1:0]      c1_req_data;
    logic [MDATA_WIDTH-1:0]     c1_req_mdata;
    logic                       c0_almfull;
    logic                       c1_almfull;
    logic                       rx0_valid;
    logic [DATA_WIDTH-1:0]      rx0_data;
    logic [MDATA_WIDTH-1:0]     rx0_mdata;
    logic                       rx1_valid;
    logic [MDATA_WIDTH-1:0]     rx1_mdata;
    logic                       overflow_err;

    modport master (
        output c0_req_valid, c0_req_addr, c0_req_mdata,
        output c1_req_valid, c1_req_addr, c1_req_data, c1_req_mdata,
        input  c0_almfull, c1_almfull, rx0_valid, rx0_data, rx0_mdata,
        input  rx1_valid, rx1_mdata, overflow_err
    );

    modport slave (
        input  c0_req_valid, c0_req_addr, c0_req_mdata,
        input  c1_req_valid, c1_req_addr, c1_req_data, c1_req_mdata,
        output c0_almfull, c1_almfull, rx0_valid, rx0_data, rx0_mdata,
        output rx1_valid, rx1_mdata, overflow_err
    );

endinterface

// File: rtl/cci_mpf_sim_rsp_queue.sv
// Per-channel request queue: stamps arrivals, holds them until they are at
// least MIN_LATENCY cycles old, then releases one per cycle.
// Build option CCI_MPF_SIM_RSP_REORDER_EN: release any ripe slot, starting
// the search at an LFSR-chosen index, instead of strict FIFO order.
module cci_mpf_sim_rsp_queue
    import cci_mpf_sim_pkg::*;
#(
    parameter int QUEUE_DEPTH   = 16,
    parameter int ALMFULL_SLACK = 4,
    parameter int MIN_LATENCY   = 8
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [STAMP_WIDTH-1:0] cycle_cnt,
    input  logic                   enq_valid,
    input  t_sim_req_entry         enq_entry,
    output logic                   deq_valid,
    output t_sim_req_entry         deq_entry,
    output logic                   almfull,
    output logic                   overflow_err
);
    localparam int IDX_W = $clog2(QUEUE_DEPTH);
    localparam logic [IDX_W:0] FULL_CNT    = (IDX_W+1)'(QUEUE_DEPTH);
    localparam logic [IDX_W:0] ALMFULL_CNT = (IDX_W+1)'(QUEUE_DEPTH - ALMFULL_SLACK);
    localparam logic [STAMP_WIDTH-1:0] MIN_LAT = STAMP_WIDTH'(MIN_LATENCY);

    t_sim_req_entry   slots [QUEUE_DEPTH];
    t_sim_req_entry   stamped;
    logic [IDX_W:0]   count, count_next;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             enq_ok, deq;

    // Modular age keeps the comparison correct across counter wrap.
    function automatic logic ripe(input logic [STAMP_WIDTH-1:0] now,
                                  input logic [STAMP_WIDTH-1:0] stamp);
        return (now - stamp) >= MIN_LAT;
    endfunction

    // Fullness is judged before this cycle's dequeue, so a full queue drops.
    assign enq_ok     = enq_valid && (count != FULL_CNT);
    assign count_next = count + (IDX_W+1)'(enq_ok) - (IDX_W+1)'(deq);
    assign deq_valid  = deq;
    assign deq_entry  = slots[rd_idx];

    // Replace the caller's stamp with the acceptance-cycle counter value.
    always_comb begin
        stamped       = enq_entry;
        stamped.stamp = cycle_cnt;
    end

`ifdef CCI_MPF_SIM_RSP_REORDER_EN
    logic [QUEUE_DEPTH-1:0] slot_vld;
    logic [STAMP_WIDTH-1:0] lfsr;
    logic [IDX_W-1:0]       start, idx;
    logic                   sel_ok;

    assign start = lfsr[IDX_W-1:0];
    assign deq   = !reset && sel_ok;
    wire unused_lfsr = &{1'b0, lfsr[STAMP_WIDTH-1:IDX_W]};

    // Lowest free slot receives the next request.
    always_comb begin
        wr_idx = '0;
        for (int i = QUEUE_DEPTH-1; i >= 0; i--)
            if (!slot_vld[i]) wr_idx = IDX_W'(i);
    end

    // First ripe slot at or above the random start, wrapping around.
    always_comb begin
        rd_idx = '0;
        sel_ok = 1'b0;
        idx    = start;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            idx = start + IDX_W'(i);
            if (!sel_ok && slot_vld[idx] && ripe(cycle_cnt, slots[idx].stamp)) begin
                sel_ok = 1'b1;
                rd_idx = idx;
            end
        end
    end

    // Slot occupancy and LFSR advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_vld <= '0;
            lfsr     <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
            if (enq_ok) slot_vld[wr_idx] <= 1'b1;
            if (deq)    slot_vld[rd_idx] <= 1'b0;
        end
    end
`else
    logic [IDX_W-1:0] wr_ptr, rd_ptr;

    assign wr_idx = wr_ptr;
    assign rd_idx = rd_ptr;
    // Only the head is tested, so later entries never overtake it.
    assign deq    = !reset && (count != '0) && ripe(cycle_cnt, slots[rd_ptr].stamp);

    // Circular FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq_ok) wr_ptr <= wr_ptr + 1'b1;
            if (deq)    rd_ptr <= rd_ptr + 1'b1;
        end
    end
`endif

    // Entry storage; no reset needed since occupancy state guards it.
    always_ff @(posedge clk) begin
        if (enq_ok) slots[wr_idx] <= stamped;
    end

    // Occupancy, registered almost-full and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            almfull      <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            count   <= count_next;
            almfull <= (count_next >= ALMFULL_CNT);
            if (enq_valid && (count == FULL_CNT)) overflow_err <= 1'b1;
        end
    end

endmodule

// File: rtl/cci_mpf_sim_host_rsp.sv
// Host-side CCI model: read queue on c0, write queue on c1, a shared backing
// line store, and single-cycle response pulses with echoed Mdata.
// Build option CCI_MPF_SIM_RSP_REORDER_EN enables out-of-order release.
module cci_mpf_sim_host_rsp
    import cci_mpf_sim_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 10,
    parameter int QUEUE_DEPTH   = 16,
    parameter int ALMFULL_SLACK = 4,
    parameter int MIN_LATENCY   = 8
)(
    input  logic                   clk,
    input  logic                   reset,
    cci_mpf_sim_host_rsp_if.slave  bus
);
    logic [STAMP_WIDTH-1:0]   cycle_cnt;
    t_sim_req_entry           c0_in, c1_in, c0_out, c1_out;
    logic                     c0_deq, c1_deq, c0_ovf, c1_ovf;
    logic [MEM_ADDR_BITS-1:0] c0_idx, c1_idx;
    logic [DATA_WIDTH-1:0]    line_mem [2**MEM_ADDR_BITS];

    logic                     rx0_valid, rx1_valid;
    logic [DATA_WIDTH-1:0]    rx0_data;
    logic [MDATA_WIDTH-1:0]   rx0_mdata, rx1_mdata;

    // Free-running stamp source.
    always_ff @(posedge clk) begin
        if (reset) cycle_cnt <= '0;
        else       cycle_cnt <= cycle_cnt + 1'b1;
    end

    assign c0_in = '{addr: bus.c0_req_addr, data: '0, mdata: bus.c0_req_mdata, stamp: '0};
    assign c1_in = '{addr: bus.c1_req_addr, data: bus.c1_req_data,
                     mdata: bus.c1_req_mdata, stamp: '0};

    cci_mpf_sim_rsp_queue #(
        .QUEUE_DEPTH(QUEUE_DEPTH), .ALMFULL_SLACK(ALMFULL_SLACK), .MIN_LATENCY(MIN_LATENCY)
    ) rd_q (
        .clk(clk), .reset(reset), .cycle_cnt(cycle_cnt),
        .enq_valid(bus.c0_req_valid), .enq_entry(c0_in),
        .deq_valid(c0_deq), .deq_entry(c0_out),
        .almfull(bus.c0_almfull), .overflow_err(c0_ovf)
    );

    cci_mpf_sim_rsp_queue #(
        .QUEUE_DEPTH(QUEUE_DEPTH), .ALMFULL_SLACK(ALMFULL_SLACK), .MIN_LATENCY(MIN_LATENCY)
    ) wr_q (
        .clk(clk), .reset(reset), .cycle_cnt(cycle_cnt),
        .enq_valid(bus.c1_req_valid), .enq_entry(c1_in),
        .deq_valid(c1_deq), .deq_entry(c1_out),
        .almfull(bus.c1_almfull), .overflow_err(c1_ovf)
    );

    // Upper address bits alias; stamps and c0 data are not needed past the queue.
    assign c0_idx = c0_out.addr[MEM_ADDR_BITS-1:0];
    assign c1_idx = c1_out.addr[MEM_ADDR_BITS-1:0];
    wire unused_ok = &{1'b0, c0_out.data, c0_out.stamp, c1_out.stamp,
                       c0_out.addr[LINE_ADDR_WIDTH-1:MEM_ADDR_BITS],
                       c1_out.addr[LINE_ADDR_WIDTH-1:MEM_ADDR_BITS]};

    // Line store write; a same-edge read sees the old line.
    always_ff @(posedge clk) begin
        if (c1_deq) line_mem[c1_idx] <= c1_out.data;
    end

    // Registered responses, one cycle after dequeue.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx0_valid <= 1'b0;
            rx0_data  <= '0;
            rx0_mdata <= '0;
            rx1_valid <= 1'b0;
            rx1_mdata <= '0;
        end else begin
            rx0_valid <= c0_deq;
            rx1_valid <= c1_deq;
            if (c0_deq) begin
                rx0_data  <= line_mem[c0_idx];
                rx0_mdata <= c0_out.mdata;
            end
            if (c1_deq) rx1_mdata <= c1_out.mdata;
        end
    end

    assign bus.rx0_valid    = rx0_valid;
    assign bus.rx0_data     = rx0_data;
    assign bus.rx0_mdata    = rx0_mdata;
    assign bus.rx1_valid    = rx1_valid;
    assign bus.rx1_mdata    = rx1_mdata;
    assign bus.overflow_err = c0_ovf | c1_ovf;

endmodule

// File: tb/tb_cci_mpf_sim_host_rsp.sv
// Scoreboard bench for cci_mpf_sim_host_rsp: a fast instance (MIN_LATENCY 8)
// for data/latency checks and a slow one (MIN_LATENCY 100) for fill/overflow.
module tb_cci_mpf_sim_host_rsp;
    import cci_mpf_sim_pkg::*;

    typedef struct {
        logic [MDATA_WIDTH-1:0] mdata;
        logic [DATA_WIDTH-1:0]  data;
        bit                     chk;
        int                     due;
    } exp_t;

    localparam logic [DATA_WIDTH-1:0] DEAD  = {16{32'hDEADBEEF}};
    localparam logic [DATA_WIDTH-1:0] LINE_A = 512'hA;
    localparam logic [DATA_WIDTH-1:0] LINE_B = 512'hB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_tests = 0, n_fail = 0;
    int   m_tests = 0, m_fail = 0;
    int   s_rx_cnt = 0, ooo_cnt = 0;
    exp_t qf0[$], qf1[$], qs0[$];

    cci_mpf_sim_host_rsp_if f();
    cci_mpf_sim_host_rsp_if s();

    cci_mpf_sim_host_rsp #(.MIN_LATENCY(8))   dut_f (.clk(clk), .reset(reset), .bus(f));
    cci_mpf_sim_host_rsp #(.MIN_LATENCY(100)) dut_s (.clk(clk), .reset(reset), .bus(s));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pop (or, when reordering is built in, search) the matching expectation.
    task automatic check_rsp(input int ch, input logic [MDATA_WIDTH-1:0] md,
                             input logic [DATA_WIDTH-1:0] d);
        exp_t q[$];
        exp_t e;
        int   k;
        case (ch)
            0: q = qf0;
            1: q = qf1;
            2: q = qs0;
            default: q = {};
        endcase
        m_tests++;
        if (q.size() == 0) begin
            m_fail++;
            $display("FAIL unexpected_rsp ch%0d: got mdata %h at cycle %0d, want no response", ch, md, cyc);
            return;
        end
        k = 0;
`ifdef CCI_MPF_SIM_RSP_REORDER_EN
        k = -1;
        for (int i = 0; i < q.size(); i++) if (k < 0 && q[i].mdata === md) k = i;
        if (k < 0) begin
            m_fail++;
            $display("FAIL rsp_mdata ch%0d: got %h, want one of %0d pending", ch, md, q.size());
            return;
        end
        if (k != 0) ooo_cnt++;
`endif
        e = q[k];
        q.delete(k);
        case (ch)
            0: qf0 = q;
            1: qf1 = q;
            default: qs0 = q;
        endcase
        if (e.mdata !== md) begin
            m_fail++;
            $display("FAIL rsp_mdata ch%0d: got %h, want %h", ch, md, e.mdata);
        end
        m_tests++;
`ifdef CCI_MPF_SIM_RSP_REORDER_EN
        if (cyc < e.due) begin
`else
        if (cyc != e.due) begin
`endif
            m_fail++;
            $display("FAIL rsp_cycle ch%0d mdata %h: got %0d, want %0d", ch, md, cyc, e.due);
        end
        if (e.chk) begin
            m_tests++;
            if (d !== e.data) begin
                m_fail++;
                $display("FAIL rsp_data ch%0d mdata %h: got %h, want %h", ch, md, d, e.data);
            end
        end
    endtask

    // Monitor: samples responses on the falling edge.
    always @(negedge clk) begin
        if (f.rx0_valid) check_rsp(0, f.rx0_mdata, f.rx0_data);
        if (f.rx1_valid) check_rsp(1, f.rx1_mdata, '0);
        if (s.rx0_valid) begin
            s_rx_cnt++;
            check_rsp(2, s.rx0_mdata, s.rx0_data);
        end
        if (s.rx1_valid) check_rsp(3, s.rx1_mdata, '0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        f.c0_req_valid = 1'b0;
        f.c1_req_valid = 1'b0;
        s.c0_req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drive a fast-instance read for the next edge; optionally expect its response.
    task automatic rd(input logic [LINE_ADDR_WIDTH-1:0] a, input logic [MDATA_WIDTH-1:0] md,
                      input logic [DATA_WIDTH-1:0] d, input bit push);
        f.c0_req_valid = 1'b1;
        f.c0_req_addr  = a;
        f.c0_req_mdata = md;
        if (push) qf0.push_back('{mdata: md, data: d, chk: 1'b1, due: cyc + 9});
    endtask

    task automatic wr(input logic [LINE_ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d,
                      input logic [MDATA_WIDTH-1:0] md);
        f.c1_req_valid = 1'b1;
        f.c1_req_addr  = a;
        f.c1_req_data  = d;
        f.c1_req_mdata = md;
        qf1.push_back('{mdata: md, data: '0, chk: 1'b0, due: cyc + 9});
    endtask

    initial begin
        f.c0_req_valid = 0; f.c0_req_addr = '0; f.c0_req_mdata = '0;
        f.c1_req_valid = 0; f.c1_req_addr = '0; f.c1_req_data = '0; f.c1_req_mdata = '0;
        s.c0_req_valid = 0; s.c0_req_addr = '0; s.c0_req_mdata = '0;
        s.c1_req_valid = 0; s.c1_req_addr = '0; s.c1_req_data = '0; s.c1_req_mdata = '0;

        idle(3);
        reset = 1'b0;
        idle(20);
        check("rst_f_rx0_valid", 64'(f.rx0_valid), 0);
        check("rst_f_rx1_valid", 64'(f.rx1_valid), 0);
        check("rst_f_rx0_mdata", 64'(f.rx0_mdata), 0);
        check("rst_f_rx0_data",  64'(f.rx0_data),  0);
        check("rst_f_almfull",   64'({f.c0_almfull, f.c1_almfull}), 0);
        check("rst_f_overflow",  64'(f.overflow_err), 0);
        check("rst_s_rx_valid",  64'({s.rx0_valid, s.rx1_valid}), 0);
        check("rst_s_almfull",   64'({s.c0_almfull, s.c1_almfull}), 0);
        check("rst_s_overflow",  64'(s.overflow_err), 0);

        // Slow instance: 17 back-to-back reads into a 16-deep queue.
        for (int i = 0; i < 17; i++) begin
            s.c0_req_valid = 1'b1;
            s.c0_req_addr  = LINE_ADDR_WIDTH'(i);
            s.c0_req_mdata = MDATA_WIDTH'(16'h100 + i);
            if (i < 16) qs0.push_back('{mdata: MDATA_WIDTH'(16'h100 + i), data: '0, chk: 1'b0, due: cyc + 101});
            step();
            if (i == 10) check("s_almfull_after_11", 64'(s.c0_almfull), 0);
            if (i == 11) check("s_almfull_after_12", 64'(s.c0_almfull), 1);
            if (i == 15) check("s_overflow_after_16", 64'(s.overflow_err), 0);
            if (i == 16) check("s_overflow_after_17", 64'(s.overflow_err), 1);
        end

        // Write then read back, including an aliased address.
        wr(42'h5, DEAD, 16'h11);
        step();
        idle(20);
        rd(42'h5, 16'h22, DEAD, 1);
        step();
        rd(42'h405, 16'h23, DEAD, 1);
        step();
        idle(20);

        // Same-edge read and write of index 7: the read sees the old line.
        wr(42'h7, LINE_A, 16'h31);
        step();
        idle(12);
        wr(42'h7, LINE_B, 16'h32);
        rd(42'h7, 16'h33, LINE_A, 1);
        step();
        idle(12);
        rd(42'h7, 16'h34, LINE_B, 1);
        step();
        idle(12);

        // Twelve back-to-back reads; occupancy peaks at 8 so almfull stays low.
        for (int i = 0; i < 12; i++) begin
            rd(42'h5, MDATA_WIDTH'(i), DEAD, 1);
            step();
        end
        check("f_almfull_burst", 64'(f.c0_almfull), 0);

        for (int t = 0; t < 400 && (qf0.size() + qf1.size() + qs0.size()) != 0; t++) step();
        check("drain_pending", 64'(qf0.size() + qf1.size() + qs0.size()), 0);
        idle(5);
        check("s_rsp_count", 64'(s_rx_cnt), 16);
        check("s_overflow_sticky", 64'(s.overflow_err), 1);
        check("s_almfull_drained", 64'(s.c0_almfull), 0);
`ifdef CCI_MPF_SIM_RSP_REORDER_EN
        check("reorder_seen", 64'(ooo_cnt > 0), 1);
`endif

        // Reset lands on the first read's dequeue edge: neither read responds.
        rd(42'h5, 16'h50, DEAD, 0);
        step();
        rd(42'h5, 16'h51, DEAD, 0);
        step();
        idle(6);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(20);
        check("midrst_s_overflow", 64'(s.overflow_err), 0);
        check("midrst_f_rx0", 64'(f.rx0_valid), 0);

        n_tests += m_tests;
        n_fail  += m_fail;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
